// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with flags and valid/ready flow control
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands over STAGES pipeline stages.
//   Each stage resolves one SLICE-bit slice with a flat lookahead carry
//   network, seeded by the registered carry out of the previous stage.
//   A global stall freezes every rank when the output beat is not taken.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset, clears every rank
//   in_valid   operand beat present
//   in_ready   beat is accepted this cycle (equals the pipeline advance)
//   a, b       operands
//   cin        carry-in, ignored when sub = 1
//   sub        1 = a - b, 0 = a + b + cin
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       result is zero (only asserted with out_valid)

module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;

  // Rank 0 holds the conditioned operands; rank k+1 holds the output of stage k.
  logic [STAGES:0]  vld;
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] res_q [STAGES+1];
  logic [STAGES:0]  cry_q;
  logic             msb_q;

  logic [WIDTH-1:0] res_n [STAGES];
  logic [STAGES-1:0] cry_n;
  logic             msb_n;
  logic [SLICE-1:0] p_s;
  logic [SLICE-1:0] g_s;
  logic [SLICE:0]   c_s;
  logic             advance;

  // Two-level lookahead: every carry is an OR of generate terms propagated
  // through the bits above them, plus the slice carry-in propagated through
  // all lower bits. No carry depends on another computed carry.
  function automatic logic [SLICE:0] lookahead(input logic [SLICE-1:0] p,
                                               input logic [SLICE-1:0] g,
                                               input logic             c_in);
    logic [SLICE:0] c;
    logic           term;
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < SLICE; i++) begin
      term = c_in;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  always_comb begin
    p_s   = '0;
    g_s   = '0;
    c_s   = '0;
    msb_n = 1'b0;
    cry_n = '0;
    for (int k = 0; k < STAGES; k++) begin
      res_n[k] = res_q[k];
      p_s = opa_q[k][k*SLICE +: SLICE] ^ opb_q[k][k*SLICE +: SLICE];
      g_s = opa_q[k][k*SLICE +: SLICE] & opb_q[k][k*SLICE +: SLICE];
      c_s = lookahead(p_s, g_s, cry_q[k]);
      res_n[k][k*SLICE +: SLICE] = p_s ^ c_s[SLICE-1:0];
      cry_n[k] = c_s[SLICE];
      // The carry into the top bit of the last slice feeds the overflow flag.
      if (k == STAGES - 1) msb_n = c_s[SLICE-1];
    end
  end

  assign advance = ~vld[STAGES] | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= '0;
      cry_q <= '0;
      msb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) res_q[k] <= '0;
    end else if (advance) begin
      vld      <= {vld[STAGES-1:0], in_valid};
      opa_q[0] <= a;
      opb_q[0] <= sub ? ~b : b;
      cry_q[0] <= sub | cin;
      res_q[0] <= '0;
      // Upper operand slices ride along until their stage consumes them.
      for (int k = 1; k < STAGES; k++) begin
        opa_q[k] <= opa_q[k-1];
        opb_q[k] <= opb_q[k-1];
      end
      // Finished lower slices are carried forward so a beat leaves whole.
      for (int k = 0; k < STAGES; k++) begin
        res_q[k+1] <= res_n[k];
        cry_q[k+1] <= cry_n[k];
      end
      msb_q <= msb_n;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld[STAGES];
  assign sum       = res_q[STAGES];
  assign cout      = cry_q[STAGES];
  assign ovf       = msb_q ^ cry_q[STAGES];
  assign zero      = vld[STAGES] & (res_q[STAGES] == '0);

endmodule
